ncpu32k_issue_sched: RTL and testbench

Dual-issue scheduler between the decoder and the two-slot backend. It takes an in-order pair of decoded instructions and issues 0, 1 or 2 of them per cycle into the stage-1 slot registers. It stalls on two kinds of hazard that the operand bypass network cannot resolve: reads or writes of a register whose LSU load is still in flight, and an intra-pair RAW or WAW dependency. It owns the single-LSU-in-flight rule and the load-pending scoreboard.

---
 rtl/ncpu32k_issue_sched_pkg.sv | 14 +
 rtl/ncpu32k_issue_sched_if.sv | 61 ++++++
 rtl/ncpu32k_load_scoreboard.sv | 64 ++++++
 rtl/ncpu32k_issue_sched.sv | 165 ++++++++++++++++
 tb/tb_ncpu32k_issue_sched.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ncpu32k_issue_sched_pkg.sv
// Shared types and widths for the dual-issue scheduler slice.
package ncpu32k_issue_sched_pkg;

    localparam int NCPU_REG_AW = 5;
    localparam int NCPU_UOP_W  = 8;

    // S_PAIR: both instructions of the pair are still outstanding.
    // S_SECOND: instruction 1 has issued, instruction 2 remains.
    typedef enum logic {
        S_PAIR   = 1'b0,
        S_SECOND = 1'b1
    } sched_state_t;

endpackage

// File: rtl/ncpu32k_issue_sched_if.sv
// Decoder-pair, stage-1 slot and LSU completion signals of the scheduler.
//
// Handshake: the decoder raises dec_AVALID with a pair and holds the pair
// stable (also while instruction 1 has already gone) until dec_AREADY is
// high in the same cycle; dec_AREADY means the whole pair was consumed.
// The s1o_*_BVALID outputs are single-cycle pulses of issued slots with
// no back-pressure of their own (the backend stalls through be_stall).
// lsu_BVALID is a single-cycle completion pulse of the one in-flight LSU op.
interface ncpu32k_issue_sched_if;
    import ncpu32k_issue_sched_pkg::*;

    logic                   dec_AVALID;
    logic                   dec_AREADY;
    logic                   dec_valid_2;
    logic                   dec_1_rs1_re, dec_1_rs2_re, dec_1_rd_we, dec_1_lsu;
    logic [NCPU_REG_AW-1:0] dec_1_rs1_addr, dec_1_rs2_addr, dec_1_rd_addr;
    logic [NCPU_UOP_W-1:0]  dec_1_uop;
    logic                   dec_2_rs1_re, dec_2_rs2_re, dec_2_rd_we, dec_2_lsu;
    logic [NCPU_REG_AW-1:0] dec_2_rs1_addr, dec_2_rs2_addr, dec_2_rd_addr;
    logic [NCPU_UOP_W-1:0]  dec_2_uop;

    logic                   s1o_slot_1_BVALID, s1o_slot_1_rd_we;
    logic [NCPU_REG_AW-1:0] s1o_slot_1_rd_addr;
    logic [NCPU_UOP_W-1:0]  s1o_slot_1_uop;
    logic                   s1o_slot_2_BVALID, s1o_slot_2_rd_we;
    logic [NCPU_REG_AW-1:0] s1o_slot_2_rd_addr;
    logic [NCPU_UOP_W-1:0]  s1o_slot_2_uop;
    logic                   s1o_lsu_AVALID, s1o_lsu_in_slot_1;

    logic                   lsu_BVALID, lsu_rd_we;
    logic [NCPU_REG_AW-1:0] lsu_rd_addr;

    sched_state_t           dbg_state;

    modport master (
        output dec_AVALID, dec_valid_2,
               dec_1_rs1_re, dec_1_rs2_re, dec_1_rd_we, dec_1_lsu,
               dec_1_rs1_addr, dec_1_rs2_addr, dec_1_rd_addr, dec_1_uop,
               dec_2_rs1_re, dec_2_rs2_re, dec_2_rd_we, dec_2_lsu,
               dec_2_rs1_addr, dec_2_rs2_addr, dec_2_rd_addr, dec_2_uop,
               lsu_BVALID, lsu_rd_we, lsu_rd_addr,
        input  dec_AREADY,
               s1o_slot_1_BVALID, s1o_slot_1_rd_we, s1o_slot_1_rd_addr, s1o_slot_1_uop,
               s1o_slot_2_BVALID, s1o_slot_2_rd_we, s1o_slot_2_rd_addr, s1o_slot_2_uop,
               s1o_lsu_AVALID, s1o_lsu_in_slot_1, dbg_state
    );

    modport slave (
        input  dec_AVALID, dec_valid_2,
               dec_1_rs1_re, dec_1_rs2_re, dec_1_rd_we, dec_1_lsu,
               dec_1_rs1_addr, dec_1_rs2_addr, dec_1_rd_addr, dec_1_uop,
               dec_2_rs1_re, dec_2_rs2_re, dec_2_rd_we, dec_2_lsu,
               dec_2_rs1_addr, dec_2_rs2_addr, dec_2_rd_addr, dec_2_uop,
               lsu_BVALID, lsu_rd_we, lsu_rd_addr,
        output dec_AREADY,
               s1o_slot_1_BVALID, s1o_slot_1_rd_we, s1o_slot_1_rd_addr, s1o_slot_1_uop,
               s1o_slot_2_BVALID, s1o_slot_2_rd_we, s1o_slot_2_rd_addr, s1o_slot_2_uop,
               s1o_lsu_AVALID, s1o_lsu_in_slot_1, dbg_state
    );

endinterface

// File: rtl/ncpu32k_load_scoreboard.sv
// Load-pending scoreboard: one pending bit per register plus the
// single-LSU-in-flight flag. Completion clears are applied before the
// hazard queries so a load result unblocks its consumer in the same cycle.
module ncpu32k_load_scoreboard
    import ncpu32k_issue_sched_pkg::*;
#(
    parameter int NREG = 32
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic                   set_rd_we,
    input  logic [NCPU_REG_AW-1:0] set_rd,
    input  logic                   clr_en,
    input  logic                   clr_rd_we,
    input  logic [NCPU_REG_AW-1:0] clr_rd,
    input  logic                   q1_rs1_re, q1_rs2_re, q1_rd_we, q1_lsu,
    input  logic [NCPU_REG_AW-1:0] q1_rs1, q1_rs2, q1_rd,
    output logic                   q1_hz,
    input  logic                   q2_rs1_re, q2_rs2_re, q2_rd_we, q2_lsu,
    input  logic [NCPU_REG_AW-1:0] q2_rs1, q2_rs2, q2_rd,
    output logic                   q2_hz
);

    logic [NREG-1:0] pend, clr_mask, set_mask, pend_eff;
    logic            lsu_busy, busy_eff;

    function automatic logic query(input logic [NREG-1:0] p, input logic busy,
                                   input logic rs1_re, input logic [NCPU_REG_AW-1:0] rs1,
                                   input logic rs2_re, input logic [NCPU_REG_AW-1:0] rs2,
                                   input logic rd_we,  input logic [NCPU_REG_AW-1:0] rd,
                                   input logic lsu);
        return (rs1_re & p[rs1]) | (rs2_re & p[rs2]) | (rd_we & p[rd]) | (lsu & busy);
    endfunction

    // Set/clear masks; r0 is never marked pending.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en && clr_rd_we)
            clr_mask[clr_rd] = 1'b1;
        if (set_en && set_rd_we && (set_rd != '0))
            set_mask[set_rd] = 1'b1;
    end

    assign pend_eff = pend & ~clr_mask;
    assign busy_eff = lsu_busy & ~clr_en;
    assign q1_hz    = query(pend_eff, busy_eff, q1_rs1_re, q1_rs1, q1_rs2_re, q1_rs2,
                            q1_rd_we, q1_rd, q1_lsu);
    assign q2_hz    = query(pend_eff, busy_eff, q2_rs1_re, q2_rs1, q2_rs2_re, q2_rs2,
                            q2_rd_we, q2_rd, q2_lsu);

    // Scoreboard update: completion clears first, a new issue sets on top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            lsu_busy <= 1'b0;
        end else begin
            pend     <= pend_eff | set_mask;
            lsu_busy <= busy_eff | set_en;
        end
    end

endmodule

// File: rtl/ncpu32k_issue_sched.sv
// Dual-issue scheduler: issues 0, 1 or 2 instructions of a decoded pair per
// cycle into the stage-1 slot registers, stalling on in-flight loads and
// intra-pair RAW/WAW/LSU conflicts.
module ncpu32k_issue_sched
    import ncpu32k_issue_sched_pkg::*;
#(
    parameter int NREG = 32
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 be_stall,
    ncpu32k_issue_sched_if.slave bus
);

    sched_state_t           state, state_nxt;
    logic                   i1_hz, i2_hz;
    logic                   i1_writes, i2_reads_rd1, raw, waw, both_lsu, load_use, pair_conflict;
    logic                   go, ready, iss_slot_1, iss_slot_2;
    logic                   slot1_lsu, slot1_rd_we, lsu_set, set_rd_we;
    logic [NCPU_REG_AW-1:0] slot1_rd, set_rd;
    logic [NCPU_UOP_W-1:0]  slot1_uop;

    logic                   s1_bv_q, s1_we_q, s2_bv_q, s2_we_q, lsu_av_q, lsu_in1_q;
    logic [NCPU_REG_AW-1:0] s1_rd_q, s2_rd_q;
    logic [NCPU_UOP_W-1:0]  s1_uop_q, s2_uop_q;

    ncpu32k_load_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (lsu_set),
        .set_rd_we (set_rd_we),
        .set_rd    (set_rd),
        .clr_en    (bus.lsu_BVALID),
        .clr_rd_we (bus.lsu_rd_we),
        .clr_rd    (bus.lsu_rd_addr),
        .q1_rs1_re (bus.dec_1_rs1_re),
        .q1_rs2_re (bus.dec_1_rs2_re),
        .q1_rd_we  (bus.dec_1_rd_we),
        .q1_lsu    (bus.dec_1_lsu),
        .q1_rs1    (bus.dec_1_rs1_addr),
        .q1_rs2    (bus.dec_1_rs2_addr),
        .q1_rd     (bus.dec_1_rd_addr),
        .q1_hz     (i1_hz),
        .q2_rs1_re (bus.dec_2_rs1_re),
        .q2_rs2_re (bus.dec_2_rs2_re),
        .q2_rd_we  (bus.dec_2_rd_we),
        .q2_lsu    (bus.dec_2_lsu),
        .q2_rs1    (bus.dec_2_rs1_addr),
        .q2_rs2    (bus.dec_2_rs2_addr),
        .q2_rd     (bus.dec_2_rd_addr),
        .q2_hz     (i2_hz)
    );

    // Intra-pair conflicts that the bypass network cannot cover. load_use is
    // a subset of raw, kept explicit so the load case reads on its own.
    assign i1_writes     = bus.dec_1_rd_we && (bus.dec_1_rd_addr != '0);
    assign i2_reads_rd1  = (bus.dec_2_rs1_re && (bus.dec_2_rs1_addr == bus.dec_1_rd_addr)) ||
                           (bus.dec_2_rs2_re && (bus.dec_2_rs2_addr == bus.dec_1_rd_addr));
    assign raw           = i1_writes && i2_reads_rd1;
    assign waw           = i1_writes && bus.dec_2_rd_we && (bus.dec_2_rd_addr == bus.dec_1_rd_addr);
    assign both_lsu      = bus.dec_1_lsu && bus.dec_2_lsu;
    assign load_use      = bus.dec_1_lsu && raw;
    assign pair_conflict = raw || waw || both_lsu || load_use;

    assign go = bus.dec_AVALID && !be_stall && !flush;

    // Issue decision and next FSM state.
    always_comb begin
        state_nxt  = state;
        iss_slot_1 = 1'b0;
        iss_slot_2 = 1'b0;
        ready      = 1'b0;
        if (go) begin
            if (state == S_PAIR) begin
                if (!i1_hz) begin
                    iss_slot_1 = 1'b1;
                    if (bus.dec_valid_2 && !i2_hz && !pair_conflict) begin
                        iss_slot_2 = 1'b1;
                        ready      = 1'b1;
                    end else if (bus.dec_valid_2) begin
                        state_nxt  = S_SECOND;
                    end else begin
                        ready      = 1'b1;
                    end
                end
            end else if (!i2_hz) begin
                iss_slot_1 = 1'b1;
                ready      = 1'b1;
                state_nxt  = S_PAIR;
            end
        end
        if (flush)
            state_nxt = S_PAIR;
    end

    // Slot 1 carries instruction 2 once instruction 1 has gone.
    assign slot1_lsu   = (state == S_SECOND) ? bus.dec_2_lsu      : bus.dec_1_lsu;
    assign slot1_rd_we = (state == S_SECOND) ? bus.dec_2_rd_we    : bus.dec_1_rd_we;
    assign slot1_rd    = (state == S_SECOND) ? bus.dec_2_rd_addr  : bus.dec_1_rd_addr;
    assign slot1_uop   = (state == S_SECOND) ? bus.dec_2_uop      : bus.dec_1_uop;

    // At most one LSU op issues per cycle, so one scoreboard set port suffices.
    assign lsu_set   = (iss_slot_1 && slot1_lsu) || (iss_slot_2 && bus.dec_2_lsu);
    assign set_rd_we = (iss_slot_1 && slot1_lsu) ? slot1_rd_we : bus.dec_2_rd_we;
    assign set_rd    = (iss_slot_1 && slot1_lsu) ? slot1_rd    : bus.dec_2_rd_addr;

    // FSM state register; be_stall freezes it through go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_PAIR;
        else
            state <= state_nxt;
    end

    // Stage-1 slot registers: flush drops valids, be_stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_bv_q   <= 1'b0;
            s2_bv_q   <= 1'b0;
            lsu_av_q  <= 1'b0;
            lsu_in1_q <= 1'b0;
            s1_we_q   <= 1'b0;
            s2_we_q   <= 1'b0;
            s1_rd_q   <= '0;
            s2_rd_q   <= '0;
            s1_uop_q  <= '0;
            s2_uop_q  <= '0;
        end else if (flush) begin
            s1_bv_q   <= 1'b0;
            s2_bv_q   <= 1'b0;
            lsu_av_q  <= 1'b0;
            lsu_in1_q <= 1'b0;
        end else if (!be_stall) begin
            s1_bv_q   <= iss_slot_1;
            s2_bv_q   <= iss_slot_2;
            lsu_av_q  <= lsu_set;
            lsu_in1_q <= iss_slot_1 && slot1_lsu;
            if (iss_slot_1) begin
                s1_we_q  <= slot1_rd_we;
                s1_rd_q  <= slot1_rd;
                s1_uop_q <= slot1_uop;
            end
            if (iss_slot_2) begin
                s2_we_q  <= bus.dec_2_rd_we;
                s2_rd_q  <= bus.dec_2_rd_addr;
                s2_uop_q <= bus.dec_2_uop;
            end
        end
    end

    assign bus.dec_AREADY         = ready;
    assign bus.s1o_slot_1_BVALID  = s1_bv_q;
    assign bus.s1o_slot_1_rd_we   = s1_we_q;
    assign bus.s1o_slot_1_rd_addr = s1_rd_q;
    assign bus.s1o_slot_1_uop     = s1_uop_q;
    assign bus.s1o_slot_2_BVALID  = s2_bv_q;
    assign bus.s1o_slot_2_rd_we   = s2_we_q;
    assign bus.s1o_slot_2_rd_addr = s2_rd_q;
    assign bus.s1o_slot_2_uop     = s2_uop_q;
    assign bus.s1o_lsu_AVALID     = lsu_av_q;
    assign bus.s1o_lsu_in_slot_1  = lsu_in1_q;
    assign bus.dbg_state          = state;

endmodule

// File: tb/tb_ncpu32k_issue_sched.sv
// Bench for ncpu32k_issue_sched: constant vector table, directed multi-cycle
// sequences and random traffic against a queue-based reference model.
module tb_ncpu32k_issue_sched;
    import ncpu32k_issue_sched_pkg::*;

    typedef struct {
        logic       rs1_re, rs2_re, rd_we, lsu;
        logic [4:0] rs1, rs2, rd;
        logic [7:0] uop;
    } ins_t;

    typedef struct {
        string name;
        ins_t  a, b;
        bit    av, v2, e_rdy, e_b1, e_b2;
    } vec_t;

    logic clk, rst, flush, be_stall;
    ncpu32k_issue_sched_if bus ();

    ncpu32k_issue_sched #(.NREG(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .be_stall (be_stall),
        .bus      (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: pending registers, in-flight LSU, pair progress
    bit [31:0] m_pend;
    bit        m_busy, m_lwe, m_half;
    bit [4:0]  m_lrd;
    bit        e_bv1, e_bv2, e_lsu, e_lsu1, e_ready;
    ins_t      e_s1, e_s2;
    logic      got_ready;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic ins_t mk(int r1e, int r1, int r2e, int r2, int we, int rd, int lsu, int uop);
        ins_t x;
        x.rs1_re = r1e != 0; x.rs1 = 5'(r1);
        x.rs2_re = r2e != 0; x.rs2 = 5'(r2);
        x.rd_we  = we != 0;  x.rd  = 5'(rd);
        x.lsu    = lsu != 0; x.uop = 8'(uop);
        return x;
    endfunction

    function automatic ins_t rand_ins();
        return mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)));
    endfunction

    function automatic vec_t mkv(string n, ins_t a, ins_t b, bit av, bit v2, bit r, bit b1, bit b2);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.av = av; v.v2 = v2;
        v.e_rdy = r; v.e_b1 = b1; v.e_b2 = b2;
        return v;
    endfunction

    // an instruction waits on any pending register it touches, or on a busy LSU
    function automatic bit blocked(input ins_t x, input bit [31:0] p, input bit busy);
        return (x.rs1_re && p[x.rs1]) || (x.rs2_re && p[x.rs2]) ||
               (x.rd_we && p[x.rd]) || (x.lsu && busy);
    endfunction

    // second instruction may not join the first one in the same cycle
    function automatic bit conflict(input ins_t f, input ins_t s);
        bit writes   = f.rd_we && (f.rd != 0);
        bit reads_rd = (s.rs1_re && s.rs1 == f.rd) || (s.rs2_re && s.rs2 == f.rd);
        return (writes && reads_rd) || (writes && s.rd_we && s.rd == f.rd) ||
               (f.lsu && s.lsu) || (f.lsu && writes && reads_rd);
    endfunction

    task automatic drive_pair(input ins_t a, input ins_t b);
        bus.dec_1_rs1_re = a.rs1_re; bus.dec_1_rs1_addr = a.rs1;
        bus.dec_1_rs2_re = a.rs2_re; bus.dec_1_rs2_addr = a.rs2;
        bus.dec_1_rd_we  = a.rd_we;  bus.dec_1_rd_addr  = a.rd;
        bus.dec_1_lsu    = a.lsu;    bus.dec_1_uop      = a.uop;
        bus.dec_2_rs1_re = b.rs1_re; bus.dec_2_rs1_addr = b.rs1;
        bus.dec_2_rs2_re = b.rs2_re; bus.dec_2_rs2_addr = b.rs2;
        bus.dec_2_rd_we  = b.rd_we;  bus.dec_2_rd_addr  = b.rd;
        bus.dec_2_lsu    = b.lsu;    bus.dec_2_uop      = b.uop;
    endtask

    task automatic model_reset();
        m_pend = '0; m_busy = 0; m_lwe = 0; m_lrd = '0; m_half = 0;
        e_bv1 = 0; e_bv2 = 0; e_lsu = 0; e_lsu1 = 0; e_ready = 0;
        e_s1 = mk(0, 0, 0, 0, 0, 0, 0, 0); e_s2 = e_s1;
    endtask

    task automatic check_outputs();
        chk("slot_1_BVALID", 32'(bus.s1o_slot_1_BVALID), 32'(e_bv1));
        chk("slot_2_BVALID", 32'(bus.s1o_slot_2_BVALID), 32'(e_bv2));
        chk("lsu_AVALID", 32'(bus.s1o_lsu_AVALID), 32'(e_lsu));
        chk("lsu_in_slot_1", 32'(bus.s1o_lsu_in_slot_1), 32'(e_lsu1));
        chk("state", 32'(bus.dbg_state), 32'(m_half));
        if (e_bv1) begin
            chk("slot_1_uop", 32'(bus.s1o_slot_1_uop), 32'(e_s1.uop));
            chk("slot_1_rd", 32'({bus.s1o_slot_1_rd_we, bus.s1o_slot_1_rd_addr}), 32'({e_s1.rd_we, e_s1.rd}));
        end
        if (e_bv2) begin
            chk("slot_2_uop", 32'(bus.s1o_slot_2_uop), 32'(e_s2.uop));
            chk("slot_2_rd", 32'({bus.s1o_slot_2_rd_we, bus.s1o_slot_2_rd_addr}), 32'({e_s2.rd_we, e_s2.rd}));
        end
    endtask

    // driver: one cycle of stimulus, checked against the model
    task automatic step(input ins_t a, input ins_t b, input bit av, input bit v2,
                        input bit st, input bit fl, input bit lbv);
        ins_t      rem[$];
        ins_t      iss[$];
        bit [31:0] eff_pend;
        bit        eff_busy, done;
        drive_pair(a, b);
        bus.dec_AVALID  = av;
        bus.dec_valid_2 = v2;
        be_stall        = st;
        flush           = fl;
        done            = lbv && m_busy;
        bus.lsu_BVALID  = done;
        bus.lsu_rd_we   = m_lwe;
        bus.lsu_rd_addr = m_lrd;
        #1;
        eff_pend = m_pend;
        if (done && m_lwe) eff_pend[m_lrd] = 1'b0;
        eff_busy = m_busy && !done;
        if (m_half) rem.push_back(b);
        else begin
            rem.push_back(a);
            if (v2) rem.push_back(b);
        end
        if (av && !st && !fl && !blocked(rem[0], eff_pend, eff_busy)) begin
            iss.push_back(rem[0]);
            if (rem.size() == 2 && !blocked(rem[1], eff_pend, eff_busy) && !conflict(rem[0], rem[1]))
                iss.push_back(rem[1]);
        end
        e_ready   = (iss.size() > 0) && (iss.size() == rem.size());
        got_ready = bus.dec_AREADY;
        chk("dec_AREADY", 32'(got_ready), 32'(e_ready));
        @(posedge clk);
        #1;
        m_pend = eff_pend;
        m_busy = eff_busy;
        if (fl) begin
            e_bv1 = 0; e_bv2 = 0; e_lsu = 0; e_lsu1 = 0; m_half = 0;
        end else if (!st) begin
            e_bv1 = iss.size() > 0;
            e_bv2 = iss.size() > 1;
            e_lsu = 0; e_lsu1 = 0;
            if (iss.size() > 0) e_s1 = iss[0];
            if (iss.size() > 1) e_s2 = iss[1];
            foreach (iss[k]) begin
                if (iss[k].lsu) begin
                    e_lsu = 1; e_lsu1 = (k == 0);
                    m_busy = 1; m_lwe = iss[k].rd_we; m_lrd = iss[k].rd;
                    if (iss[k].rd_we && iss[k].rd != 0) m_pend[iss[k].rd] = 1'b1;
                end
            end
            if (iss.size() > 0) m_half = !e_ready;
        end
        check_outputs();
    endtask

    vec_t vt[$];
    ins_t nop, a, b;
    bit   av, v2, fl;

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; flush = 1'b0; be_stall = 1'b0;
        drive_pair(nop, nop);
        bus.dec_AVALID = 0; bus.dec_valid_2 = 0;
        bus.lsu_BVALID = 0; bus.lsu_rd_we = 0; bus.lsu_rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset slot_1_BVALID", 32'(bus.s1o_slot_1_BVALID), 32'd0);
        chk("reset slot_2_BVALID", 32'(bus.s1o_slot_2_BVALID), 32'd0);
        chk("reset lsu_AVALID", 32'(bus.s1o_lsu_AVALID), 32'd0);
        chk("reset slot_1_uop", 32'(bus.s1o_slot_1_uop), 32'd0);
        chk("reset state", 32'(bus.dbg_state), 32'(S_PAIR));
        rst = 1'b0;

        // vector table: each record starts from an idle scheduler
        vt.push_back(mkv("indep", mk(1,2,1,3,1,1,0,8'h01), mk(1,5,1,6,1,4,0,8'h02), 1,1, 1,1,1));
        vt.push_back(mkv("raw", mk(1,2,1,3,1,1,0,8'h03), mk(1,1,1,2,1,7,0,8'h04), 1,1, 0,1,0));
        vt.push_back(mkv("waw", mk(1,2,1,3,1,1,0,8'h05), mk(1,4,1,5,1,1,0,8'h06), 1,1, 0,1,0));
        vt.push_back(mkv("r0_dest", mk(1,2,1,3,1,0,0,8'h07), mk(1,0,1,5,1,4,0,8'h08), 1,1, 1,1,1));
        vt.push_back(mkv("single", mk(1,2,1,3,1,1,0,8'h09), nop, 1,0, 1,1,0));
        vt.push_back(mkv("raw_rs2", mk(1,2,0,0,1,3,0,8'h0a), mk(1,2,1,3,1,8,0,8'h0b), 1,1, 0,1,0));
        vt.push_back(mkv("re_off", mk(1,5,0,0,1,9,0,8'h0c), mk(0,9,1,1,1,2,0,8'h0d), 1,1, 1,1,1));
        vt.push_back(mkv("we_off", mk(1,5,0,0,0,4,0,8'h0e), mk(1,4,0,0,1,2,0,8'h0f), 1,1, 1,1,1));
        vt.push_back(mkv("war", mk(1,4,0,0,1,2,0,8'h10), mk(1,1,0,0,1,4,0,8'h11), 1,1, 1,1,1));
        vt.push_back(mkv("ld_alu", mk(1,2,0,0,1,10,1,8'h12), mk(1,12,1,13,1,11,0,8'h13), 1,1, 1,1,1));
        vt.push_back(mkv("two_lsu", mk(1,2,0,0,0,0,1,8'h14), mk(1,2,0,0,1,3,1,8'h15), 1,1, 0,1,0));
        vt.push_back(mkv("ld_use", mk(1,2,0,0,1,10,1,8'h16), mk(1,10,0,0,1,6,0,8'h17), 1,1, 0,1,0));
        vt.push_back(mkv("no_valid", mk(1,2,1,3,1,1,0,8'h18), mk(1,5,1,6,1,4,0,8'h19), 0,1, 0,0,0));
        foreach (vt[i]) begin
            step(vt[i].a, vt[i].b, vt[i].av, vt[i].v2, 0, 0, 0);
            chk({vt[i].name, " ready"}, 32'(got_ready), 32'(vt[i].e_rdy));
            chk({vt[i].name, " bv1"}, 32'(bus.s1o_slot_1_BVALID), 32'(vt[i].e_b1));
            chk({vt[i].name, " bv2"}, 32'(bus.s1o_slot_2_BVALID), 32'(vt[i].e_b2));
            step(nop, nop, 0, 0, 0, 1, 1);
        end

        // load r5 in flight, consumer r6=r5+r1 waits for its completion
        a = mk(1,2,0,0,1,5,1,8'h21);
        b = mk(1,5,1,1,1,6,0,8'h22);
        step(a, nop, 1, 0, 0, 0, 0);
        chk("ld5 ready", 32'(got_ready), 32'd1);
        chk("ld5 lsu_AVALID", 32'(bus.s1o_lsu_AVALID), 32'd1);
        step(b, nop, 1, 0, 0, 0, 0);
        chk("use5 held", 32'(got_ready), 32'd0);
        step(b, nop, 1, 0, 0, 0, 0);
        chk("use5 held2", 32'(bus.s1o_slot_1_BVALID), 32'd0);
        step(b, nop, 1, 0, 0, 0, 1);
        chk("use5 on completion", 32'(got_ready), 32'd1);
        chk("use5 uop", 32'(bus.s1o_slot_1_uop), 32'h22);
        step(mk(1,5,1,0,1,7,0,8'h23), nop, 1, 0, 0, 0, 0);
        chk("r5 cleared", 32'(got_ready), 32'd1);

        // two LSU ops in one pair split; second waits for lsu_busy
        a = mk(1,2,0,0,1,10,1,8'h31);
        b = mk(1,2,0,0,1,11,1,8'h32);
        step(a, b, 1, 1, 0, 0, 0);
        chk("2lsu split ready", 32'(got_ready), 32'd0);
        chk("2lsu split bv2", 32'(bus.s1o_slot_2_BVALID), 32'd0);
        step(a, b, 1, 1, 0, 0, 0);
        chk("2lsu busy", 32'(bus.s1o_slot_1_BVALID), 32'd0);
        step(a, b, 1, 1, 0, 0, 1);
        chk("2lsu second ready", 32'(got_ready), 32'd1);
        chk("2lsu in_slot_1", 32'(bus.s1o_lsu_in_slot_1), 32'd1);
        step(nop, nop, 0, 0, 0, 1, 1);

        // be_stall for 3 cycles while in S_SECOND
        a = mk(1,2,1,3,1,1,0,8'h41);
        b = mk(1,1,1,2,1,7,0,8'h42);
        step(a, b, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(a, b, 1, 1, 1, 0, 0);
            chk("stall ready", 32'(got_ready), 32'd0);
            chk("stall hold uop", 32'(bus.s1o_slot_1_uop), 32'h41);
            chk("stall hold state", 32'(bus.dbg_state), 32'(S_SECOND));
        end
        step(a, b, 1, 1, 0, 0, 0);
        chk("stall release", 32'(bus.s1o_slot_1_uop), 32'h42);
        step(nop, nop, 0, 0, 0, 0, 0);
        chk("no duplicate", 32'(bus.s1o_slot_1_BVALID), 32'd0);

        // flush in S_SECOND with load r9 pending
        a = mk(1,2,0,0,1,9,1,8'h51);
        b = mk(1,9,1,1,1,11,0,8'h52);
        step(a, b, 1, 1, 0, 0, 0);
        chk("ld9 state", 32'(bus.dbg_state), 32'(S_SECOND));
        step(a, b, 1, 1, 0, 1, 0);
        chk("flush bv1", 32'(bus.s1o_slot_1_BVALID), 32'd0);
        chk("flush state", 32'(bus.dbg_state), 32'(S_PAIR));
        b = mk(1,9,1,4,1,13,0,8'h53);
        step(b, nop, 1, 0, 0, 0, 0);
        chk("r9 still pending", 32'(got_ready), 32'd0);
        step(b, nop, 1, 0, 0, 0, 1);
        chk("r9 completion", 32'(got_ready), 32'd1);

        // asynchronous reset in the middle of operation
        step(mk(1,2,0,0,1,12,1,8'h61), nop, 1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async rst bv1", 32'(bus.s1o_slot_1_BVALID), 32'd0);
        chk("async rst lsu", 32'(bus.s1o_lsu_AVALID), 32'd0);
        chk("async rst uop", 32'(bus.s1o_slot_1_uop), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(mk(1,12,0,0,1,14,0,8'h62), nop, 1, 0, 0, 0, 0);
        chk("r12 cleared by rst", 32'(got_ready), 32'd1);

        // random traffic; the decoder holds each pair until it is consumed
        a = rand_ins(); b = rand_ins(); v2 = 1; av = 1;
        for (int n = 0; n < 3000; n++) begin
            fl = ($urandom_range(0, 39) == 0);
            step(a, b, av, v2, $urandom_range(0, 5) == 0, fl, $urandom_range(0, 2) == 0);
            if (e_ready || fl || !av) begin
                a  = rand_ins();
                b  = rand_ins();
                v2 = ($urandom_range(0, 3) != 0);
                av = ($urandom_range(0, 7) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
